// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: accepts one instruction, reads its
// operands from an external register file, executes it and writes back.
// Every instruction takes exactly four cycles (IDLE, READ, EXEC, WRITE).
module instr_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    localparam int INSTR_WIDTH  = 4 + 3 * ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic                     rf_r_en_one,
    output logic                     rf_r_en_two,
    output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_one,
    output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_two,
    input  logic [DATA_WIDTH-1:0]    rf_r_data_one,
    input  logic [DATA_WIDTH-1:0]    rf_r_data_two,
    output logic                     rf_w_en,
    output logic [ADDRESS_WIDTH-1:0] rf_w_adrs,
    output logic [DATA_WIDTH-1:0]    rf_w_data,
    output logic                     done,
    output logic                     illegal,
    output logic [15:0]              retired_count
);

    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
    localparam int AW          = ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
        OP_OR  = 4'd4, OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_LDI = 4'd8, OP_MOV = 4'd9
    } opcode_t;

    state_t                  state;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [DATA_WIDTH-1:0]   result;
    logic [DATA_WIDTH-1:0]   alu;
    logic                    ready_q;
    logic                    r_en_one_q;
    logic                    r_en_two_q;
    logic                    w_en_q;
    logic                    done_q;
    logic                    illegal_q;

    // Field views of the latched instruction.
    logic [3:0]        op_bits;
    logic [AW-1:0]     dst_q;
    logic [AW-1:0]     src1_q;
    logic [AW-1:0]     src2_q;
    logic [2*AW-1:0]   imm_q;
    logic [3:0]        new_op;

    assign op_bits = instr_q[INSTR_WIDTH-1 -: 4];
    assign dst_q   = instr_q[3*AW-1 -: AW];
    assign src1_q  = instr_q[2*AW-1 -: AW];
    assign src2_q  = instr_q[AW-1:0];
    assign imm_q   = instr_q[2*AW-1:0];
    assign new_op  = instr[INSTR_WIDTH-1 -: 4];

    function automatic logic reads_one(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd7)) || (op == 4'd9);
    endfunction

    function automatic logic reads_two(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic writes_back(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd9);
    endfunction

    // Execute stage: operand data from the register file is valid in EXEC.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // alu unassigned, which would otherwise infer a latch.
        alu = '0;
        case (opcode_t'(op_bits))
            OP_ADD:  alu = rf_r_data_one + rf_r_data_two;
            OP_SUB:  alu = rf_r_data_one - rf_r_data_two;
            OP_AND:  alu = rf_r_data_one & rf_r_data_two;
            OP_OR:   alu = rf_r_data_one | rf_r_data_two;
            OP_XOR:  alu = rf_r_data_one ^ rf_r_data_two;
            OP_SHL:  alu = rf_r_data_one << rf_r_data_two[SHIFT_WIDTH-1:0];
            OP_SHR:  alu = rf_r_data_one >> rf_r_data_two[SHIFT_WIDTH-1:0];
            OP_LDI:  alu = DATA_WIDTH'(imm_q);
            OP_MOV:  alu = rf_r_data_one;
            default: alu = '0;
        endcase
    end

    // Sequencer FSM with all control outputs registered on state entry.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so the order of statements below does not matter.
        if (reset) begin
            state         <= IDLE;
            instr_q       <= '0;
            result        <= '0;
            retired_count <= '0;
            ready_q       <= 1'b1;
            r_en_one_q    <= 1'b0;
            r_en_two_q    <= 1'b0;
            w_en_q        <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && ready_q) begin
                        instr_q    <= instr;
                        ready_q    <= 1'b0;
                        r_en_one_q <= reads_one(new_op);
                        r_en_two_q <= reads_two(new_op);
                        state      <= READ;
                    end
                end
                READ: begin
                    r_en_one_q <= 1'b0;
                    r_en_two_q <= 1'b0;
                    state      <= EXEC;
                end
                EXEC: begin
                    result        <= alu;
                    w_en_q        <= writes_back(op_bits);
                    done_q        <= 1'b1;
                    illegal_q     <= (op_bits >= 4'd10);
                    retired_count <= retired_count + 16'd1;
                    state         <= WRITE;
                end
                WRITE: begin
                    w_en_q    <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces every handshake/enable low immediately, even while the
    // registered copies still hold their pre-reset values.
    assign instr_ready   = ready_q    & ~reset;
    assign rf_r_en_one   = r_en_one_q & ~reset;
    assign rf_r_en_two   = r_en_two_q & ~reset;
    assign rf_w_en       = w_en_q     & ~reset;
    assign done          = done_q     & ~reset;
    assign illegal       = illegal_q  & ~reset;

    assign rf_r_adrs_one = src1_q;
    assign rf_r_adrs_two = src2_q;
    assign rf_w_adrs     = dst_q;
    assign rf_w_data     = result;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a negedge-sampling register
// file model; the monitor checks every retire against queued expectations.
module tb_instr_sequencer;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int IW = 4 + 3 * AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          rf_r_en_one, rf_r_en_two;
    logic [AW-1:0] rf_r_adrs_one, rf_r_adrs_two;
    logic [DW-1:0] rf_r_data_one, rf_r_data_two;
    logic          rf_w_en;
    logic [AW-1:0] rf_w_adrs;
    logic [DW-1:0] rf_w_data;
    logic          done, illegal;
    logic [15:0]   retired_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          w_en;
        logic [AW-1:0] adrs;
        logic [DW-1:0] data;
        logic          ill;
        logic [15:0]   cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count;
    logic [DW-1:0] mem [4096];

    always #5 clk = ~clk;

    instr_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .rf_r_en_one(rf_r_en_one), .rf_r_en_two(rf_r_en_two),
        .rf_r_adrs_one(rf_r_adrs_one), .rf_r_adrs_two(rf_r_adrs_two),
        .rf_r_data_one(rf_r_data_one), .rf_r_data_two(rf_r_data_two),
        .rf_w_en(rf_w_en), .rf_w_adrs(rf_w_adrs), .rf_w_data(rf_w_data),
        .done(done), .illegal(illegal), .retired_count(retired_count)
    );

    // Register file model: reads and writes happen on the falling edge.
    always @(negedge clk) begin
        if (rf_w_en)     mem[rf_w_adrs] <= rf_w_data;
        if (rf_r_en_one) rf_r_data_one  <= mem[rf_r_adrs_one];
        if (rf_r_en_two) rf_r_data_two  <= mem[rf_r_adrs_two];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retire pops one expectation; stray writes are errors.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rf_w_en && !done) begin
            n_checks++;
            n_errors++;
            $display("FAIL w_en_without_done: got rf_w_en=1 with done=0");
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1, expected no retire");
            end else begin
                e = sb.pop_front();
                check("retire_w_en", 32'(rf_w_en), 32'(e.w_en));
                check("retire_illegal", 32'(illegal), 32'(e.ill));
                check("retire_count", 32'(retired_count), 32'(e.cnt));
                if (e.w_en) begin
                    check("retire_w_adrs", 32'(rf_w_adrs), 32'(e.adrs));
                    check("retire_w_data", rf_w_data, e.data);
                end
            end
        end
    end

    // Issue one instruction; returns after the READ-cycle checks with the
    // number of idle negedges spent waiting for instr_ready.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic e1, input logic e2, input logic ew,
                         input logic [DW-1:0] edata, input logic eill,
                         input logic push, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got instr_ready=0 for %0d cycles", waited);
            return;
        end
        instr       = {op, dst, s1, s2};
        instr_valid = 1'b1;
        if (push) begin
            exp_count = exp_count + 16'd1;
            e.w_en = ew; e.adrs = dst; e.data = edata; e.ill = eill; e.cnt = exp_count;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        instr = '1;  // later changes to instr must not disturb the latched one
        check("ready_low_after_accept", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("read_en_one", 32'(rf_r_en_one), 32'(e1));
        check("read_en_two", 32'(rf_r_en_two), 32'(e2));
        if (e1) check("read_adrs_one", 32'(rf_r_adrs_one), 32'(s1));
        if (e2) check("read_adrs_two", 32'(rf_r_adrs_two), 32'(s2));
    endtask

    task automatic drop_valid;
        instr_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        exp_count   = 16'd0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", 32'(instr_ready), 32'd0);
            check("reset_w_en", 32'(rf_w_en), 32'd0);
            check("reset_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("ready_after_reset", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check("count_after_reset", 32'(retired_count), 32'd0);

        // LDI r3=5, LDI r4=7, ADD r5=r3+r4
        issue(4'd8, 12'd3, 12'h000, 12'h005, 0, 0, 1, 32'h5, 0, 1, w); drop_valid();
        issue(4'd8, 12'd4, 12'h000, 12'h007, 0, 0, 1, 32'h7, 0, 1, w); drop_valid();
        issue(4'd1, 12'd5, 12'd3, 12'd4, 1, 1, 1, 32'h0000000C, 0, 1, w); drop_valid();
        // SUB wraps; then SHL by r4[4:0] after r4=0x21
        issue(4'd2, 12'd6, 12'd3, 12'd4, 1, 1, 1, 32'hFFFFFFFE, 0, 1, w); drop_valid();
        issue(4'd8, 12'd4, 12'h000, 12'h021, 0, 0, 1, 32'h21, 0, 1, w); drop_valid();
        issue(4'd6, 12'd7, 12'd3, 12'd4, 1, 1, 1, 32'h0000000A, 0, 1, w); drop_valid();
        // SHR 0x21 by 4 (r9=0x24 -> amount 4), AND/OR/XOR, MOV
        issue(4'd8, 12'd9, 12'h000, 12'h024, 0, 0, 1, 32'h24, 0, 1, w); drop_valid();
        issue(4'd7, 12'd8, 12'd4, 12'd9, 1, 1, 1, 32'h2, 0, 1, w); drop_valid();
        issue(4'd3, 12'd10, 12'd3, 12'd4, 1, 1, 1, 32'h1, 0, 1, w); drop_valid();
        issue(4'd4, 12'd11, 12'd3, 12'd4, 1, 1, 1, 32'h25, 0, 1, w); drop_valid();
        issue(4'd5, 12'd12, 12'd3, 12'd4, 1, 1, 1, 32'h24, 0, 1, w); drop_valid();
        issue(4'd9, 12'd13, 12'd4, 12'd0, 1, 0, 1, 32'h21, 0, 1, w); drop_valid();
        // LDI with full 24-bit immediate
        issue(4'd8, 12'd14, 12'hABC, 12'hDEF, 0, 0, 1, 32'h00ABCDEF, 0, 1, w); drop_valid();
        // dst == sources, then a dependent read of the new value
        issue(4'd1, 12'd3, 12'd3, 12'd3, 1, 1, 1, 32'hA, 0, 1, w); drop_valid();
        issue(4'd9, 12'd15, 12'd3, 12'd0, 1, 0, 1, 32'hA, 0, 1, w); drop_valid();
        // Illegal opcode 0xC and NOP: retire without a write
        issue(4'hC, 12'd1, 12'd2, 12'd3, 0, 0, 0, 32'h0, 1, 1, w); drop_valid();
        issue(4'h0, 12'd1, 12'd2, 12'd3, 0, 0, 0, 32'h0, 0, 1, w); drop_valid();
        drain();

        // instr_valid held high: accept every 4 cycles, doubling chain
        issue(4'd8, 12'd5, 12'h000, 12'h001, 0, 0, 1, 32'h1, 0, 1, w);
        issue(4'd1, 12'd5, 12'd5, 12'd5, 1, 1, 1, 32'h2, 0, 1, w);
        check("b2b_gap", 32'(w), 32'd2);
        issue(4'd1, 12'd5, 12'd5, 12'd5, 1, 1, 1, 32'h4, 0, 1, w);
        check("b2b_gap", 32'(w), 32'd2);
        issue(4'd1, 12'd5, 12'd5, 12'd5, 1, 1, 1, 32'h8, 0, 1, w);
        check("b2b_gap", 32'(w), 32'd2);
        issue(4'd1, 12'd5, 12'd5, 12'd5, 1, 1, 1, 32'h10, 0, 1, w);
        check("b2b_gap", 32'(w), 32'd2);
        drop_valid();
        drain();

        // Reset pulsed during EXEC of an ADD: the instruction is aborted
        issue(4'd1, 12'd5, 12'd5, 12'd5, 1, 1, 1, 32'h0, 0, 0, w); drop_valid();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_ready_in_reset", 32'(instr_ready), 32'd0);
        check("abort_done_in_reset", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_count = 16'd0;
        #1 check("abort_ready_after", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check("abort_w_en", 32'(rf_w_en), 32'd0);
        check("abort_count", 32'(retired_count), 32'd0);
        repeat (5) @(negedge clk);
        check("abort_no_write_r5", mem[5], 32'h10);

        // Counter wrap: preload just below the wrap point, then two NOPs
        @(negedge clk);
        force dut.retired_count = 16'hFFFE;
        @(posedge clk);
        #1 release dut.retired_count;
        exp_count = 16'hFFFE;
        issue(4'h0, 12'd0, 12'd0, 12'd0, 0, 0, 0, 32'h0, 0, 1, w); drop_valid();
        issue(4'h0, 12'd0, 12'd0, 12'd0, 0, 0, 0, 32'h0, 0, 1, w); drop_valid();
        drain();
        check("count_wrapped", 32'(retired_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, register address width; INSTR_WIDTH = 4 + 3*ADDRESS_WIDTH.
REQ-003 The block SHALL have one clock and one synchronous, active-high reset, on the ports below.
REQ-004 Port: clk  in  1  clock; all state updates on posedge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: instr  in  INSTR_WIDTH  opcode [top 4 bits], dst, src1, src2 (ADDRESS_WIDTH each, MSB to LSB).
REQ-007 Port: instr_valid  in  1  instr is valid.
REQ-008 Port: instr_ready  out  1  block can accept an instruction.
REQ-009 Port: rf_r_en_one, rf_r_en_two  out  1 each  register file read enables.
REQ-010 Port: rf_r_adrs_one, rf_r_adrs_two  out  ADDRESS_WIDTH each  read addresses.
REQ-011 Port: rf_r_data_one, rf_r_data_two  in  DATA_WIDTH each  read data from the register file.
REQ-012 Port: rf_w_en  out  1  register file write enable.
REQ-013 Port: rf_w_adrs  out  ADDRESS_WIDTH  write address.
REQ-014 Port: rf_w_data  out  DATA_WIDTH  write data.
REQ-015 Port: done  out  1  one-cycle retire pulse.
REQ-016 Port: illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode.
REQ-017 Port: retired_count  out  16  count of retired instructions.

Function
REQ-018 The FSM SHALL have states IDLE, READ, EXEC and WRITE, with transitions as follows.
- IDLE->READ on instr_valid && instr_ready.
- READ->EXEC, EXEC->WRITE and WRITE->IDLE unconditionally.
REQ-019 instr_ready SHALL be 1 only in IDLE; the instruction SHALL be latched on the accepting edge, and instr changes after acceptance SHALL have no effect.
REQ-020 In READ, rf_r_en_one/two SHALL be 1 with adrs = latched src1/src2, for opcodes 1-7 and 9 (MOV uses en_one only); all other opcodes SHALL assert no read enable.
REQ-021 The register file samples on negedge, so rf_r_data_* SHALL be treated as valid in EXEC; the result SHALL be registered at the EXEC->WRITE edge.
REQ-022 Opcodes:
- 0 NOP; 1 ADD; 2 SUB (src1-src2); 3 AND; 4 OR; 5 XOR.
- 6 SHL src1 by src2[$clog2(DATA_WIDTH)-1:0]; 7 SHR logical, same shift amount.
- 8 LDI: {src1,src2} fields zero-extended or truncated to DATA_WIDTH.
- 9 MOV: src1 data.
- 10-15 illegal.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; no carry or overflow output.
REQ-024 In WRITE, rf_w_en SHALL be 1 with rf_w_adrs=dst and rf_w_data=result, for opcodes 1-9 only.
REQ-025 In WRITE, done SHALL pulse for every opcode; illegal SHALL pulse for opcodes 10-15.
REQ-026 Latency SHALL be fixed for all opcodes: the accept edge at cycle N gives rf_w_en/done high during cycle N+3, with instr_ready high again in cycle N+4.
REQ-027 Throughput SHALL be one instruction per 4 cycles.
REQ-028 Back-to-back dependent instructions SHALL read the updated value with no stall: the write occurs on the negedge in WRITE, before the next READ.
REQ-029 dst equal to src1/src2 SHALL be legal; the sources SHALL be read before the write.
REQ-030 retired_count SHALL increment on each done, including NOP and illegal, and SHALL wrap 0xFFFF->0x0000.
REQ-031 All outputs other than the rf_*_adrs/data buses SHALL be 0 outside the states defined above.

Reset
REQ-032 Reset SHALL return the FSM to IDLE and SHALL clear the latched instruction, result and retired_count.
REQ-033 During reset, all enables, done and illegal SHALL be 0.
REQ-034 instr_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-035 Reset asserted in any state SHALL abort the instruction with no rf_w_en and no done; reset SHALL take precedence over instr_valid.

Verification
REQ-036 LDI dst=3, imm=0x000005, then LDI dst=4, imm=0x000007, then ADD dst=5,src1=3,src2=4 -> the third WRITE has rf_w_adrs=5, rf_w_data=0x0000000C, done=1, retired_count=3.
REQ-037 r3=5, r4=7: SUB dst=6,3,4 -> rf_w_data=0xFFFFFFFE; then SHL dst=7,src1=3,src2=4 with r4=0x21 -> 0x0000000A (shift amount 1).
REQ-038 Opcode 0xC -> done=1, illegal=1, rf_w_en=0, retired_count increments; NOP -> done=1, illegal=0, rf_w_en=0.
REQ-039 instr_valid held high continuously -> an accept every 4 cycles, instr_ready low in READ/EXEC/WRITE, and a dependent ADD r5=r5+r5 chain doubles the value on each retire.
REQ-040 Reset pulsed in EXEC of an ADD -> no rf_w_en, no done, instr_ready=1 on the first cycle after reset deasserts, retired_count=0.
REQ-041 retired_count preset near wrap via 65536 NOPs -> reads 0x0000 after the 65536th retire.
